// File: rtl/vga_timing_gen_if.sv
// Bus between the VGA timing generator, the framebuffer read port and the VGA pins.
// The pattern_sel signal exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_timing_gen_if #(
   parameter int X_W     = 10,
   parameter int Y_W     = 10,
   parameter int PIXEL_W = 8
);
   logic               pix_en;
   logic [X_W-1:0]     fetch_x;
   logic [Y_W-1:0]     fetch_y;
   logic               fetch_valid;
   logic [PIXEL_W-1:0] pixel_in;
   logic [PIXEL_W-1:0] pixel_out;
   logic               hsync;
   logic               vsync;
   logic               de;
   logic               line_start;
   logic               frame_start;
   logic [7:0]         frame_cnt;
`ifdef VGA_TEST_PATTERN_EN
   logic               pattern_sel;
`endif

   modport master (
      output fetch_x, fetch_y, fetch_valid, pixel_out, hsync, vsync, de,
             line_start, frame_start, frame_cnt,
      input  pix_en, pixel_in
`ifdef VGA_TEST_PATTERN_EN
      , pattern_sel
`endif
   );

   modport slave (
      input  fetch_x, fetch_y, fetch_valid, pixel_out, hsync, vsync, de,
             line_start, frame_start, frame_cnt,
      output pix_en, pixel_in
`ifdef VGA_TEST_PATTERN_EN
      , pattern_sel
`endif
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with latency-compensated framebuffer fetch.
// Optional built-in x^y test pattern when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int PIXEL_W   = 8,
   parameter int HSYNC_POL = 0,
   parameter int VSYNC_POL = 0,
   parameter int FETCH_LAT = 1
) (
   input  logic clk,
   input  logic rst,
   vga_timing_gen_if.master bus
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int X_W     = $clog2(H_TOTAL);
   localparam int Y_W     = $clog2(V_TOTAL);
   localparam int XY_W    = (X_W > Y_W) ? X_W : Y_W;

   // Compare constants carry one spare bit so a sync end equal to the total still fits.
   localparam logic [X_W:0] H_ACT_END = (X_W+1)'(H_ACTIVE);
   localparam logic [X_W:0] H_SYN_BEG = (X_W+1)'(H_ACTIVE + H_FP);
   localparam logic [X_W:0] H_SYN_END = (X_W+1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [Y_W:0] V_ACT_END = (Y_W+1)'(V_ACTIVE);
   localparam logic [Y_W:0] V_SYN_BEG = (Y_W+1)'(V_ACTIVE + V_FP);
   localparam logic [Y_W:0] V_SYN_END = (Y_W+1)'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [X_W-1:0] H_LAST  = X_W'(H_TOTAL - 1);
   localparam logic [Y_W-1:0] V_LAST  = Y_W'(V_TOTAL - 1);
   localparam logic HS_ON = (HSYNC_POL != 0);
   localparam logic VS_ON = (VSYNC_POL != 0);

   logic [X_W-1:0]       r_hc;
   logic [Y_W-1:0]       r_vc;
   logic [7:0]           r_frameCnt;

   logic                 w_hcLast;
   logic                 w_vcLast;
   logic                 w_deRaw;
   logic                 w_hsRaw;
   logic                 w_vsRaw;
   logic                 w_firstRaw;
   logic                 w_frameRaw;

   logic [FETCH_LAT-1:0] r_dePipe;
   logic [FETCH_LAT-1:0] r_hsPipe;
   logic [FETCH_LAT-1:0] r_vsPipe;
   logic [FETCH_LAT-1:0] r_firstPipe;
   logic [FETCH_LAT-1:0] r_framePipe;
`ifdef VGA_TEST_PATTERN_EN
   logic [X_W-1:0]       r_xPipe [FETCH_LAT];
   logic [Y_W-1:0]       r_yPipe [FETCH_LAT];
`endif

   logic [PIXEL_W-1:0]   w_pixelNext;
   logic [PIXEL_W-1:0]   r_pixelOut;
   logic                 r_de;
   logic                 r_hsync;
   logic                 r_vsync;
   logic                 r_lineStart;
   logic                 r_frameStart;

   assign w_hcLast   = (r_hc == H_LAST);
   assign w_vcLast   = (r_vc == V_LAST);
   assign w_deRaw    = ({1'b0, r_hc} < H_ACT_END) && ({1'b0, r_vc} < V_ACT_END);
   assign w_hsRaw    = ({1'b0, r_hc} >= H_SYN_BEG) && ({1'b0, r_hc} < H_SYN_END);
   assign w_vsRaw    = ({1'b0, r_vc} >= V_SYN_BEG) && ({1'b0, r_vc} < V_SYN_END);
   assign w_firstRaw = (r_hc == '0);
   assign w_frameRaw = (r_hc == '0) && (r_vc == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hc       <= '0;
         r_vc       <= '0;
         r_frameCnt <= '0;
      end else if (bus.pix_en) begin
         if (w_hcLast) begin
            r_hc <= '0;
            if (w_vcLast) begin
               r_vc       <= '0;
               r_frameCnt <= r_frameCnt + 8'd1;
            end else begin
               r_vc <= r_vc + Y_W'(1);
            end
         end else begin
            r_hc <= r_hc + X_W'(1);
         end
      end
   end

   // Sideband delay line matches the framebuffer read latency so data and timing meet at the output.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dePipe    <= '0;
         r_hsPipe    <= '0;
         r_vsPipe    <= '0;
         r_firstPipe <= '0;
         r_framePipe <= '0;
      end else if (bus.pix_en) begin
         for (int i = FETCH_LAT - 1; i > 0; i--) begin
            r_dePipe[i]    <= r_dePipe[i-1];
            r_hsPipe[i]    <= r_hsPipe[i-1];
            r_vsPipe[i]    <= r_vsPipe[i-1];
            r_firstPipe[i] <= r_firstPipe[i-1];
            r_framePipe[i] <= r_framePipe[i-1];
         end
         r_dePipe[0]    <= w_deRaw;
         r_hsPipe[0]    <= w_hsRaw;
         r_vsPipe[0]    <= w_vsRaw;
         r_firstPipe[0] <= w_firstRaw;
         r_framePipe[0] <= w_frameRaw;
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FETCH_LAT; i++) begin
            r_xPipe[i] <= '0;
            r_yPipe[i] <= '0;
         end
      end else if (bus.pix_en) begin
         for (int i = FETCH_LAT - 1; i > 0; i--) begin
            r_xPipe[i] <= r_xPipe[i-1];
            r_yPipe[i] <= r_yPipe[i-1];
         end
         r_xPipe[0] <= r_hc;
         r_yPipe[0] <= r_vc;
      end
   end
`endif

   always_comb begin
      w_pixelNext = '0;
      if (r_dePipe[FETCH_LAT-1]) begin
`ifdef VGA_TEST_PATTERN_EN
         if (bus.pattern_sel)
            w_pixelNext = PIXEL_W'(XY_W'(r_xPipe[FETCH_LAT-1]) ^ XY_W'(r_yPipe[FETCH_LAT-1]));
         else
            w_pixelNext = bus.pixel_in;
`else
         w_pixelNext = bus.pixel_in;
`endif
      end
   end

   // Start pulses last exactly one clk: any clk without pix_en drops them.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pixelOut   <= '0;
         r_de         <= 1'b0;
         r_hsync      <= ~HS_ON;
         r_vsync      <= ~VS_ON;
         r_lineStart  <= 1'b0;
         r_frameStart <= 1'b0;
      end else if (bus.pix_en) begin
         r_pixelOut   <= w_pixelNext;
         r_de         <= r_dePipe[FETCH_LAT-1];
         r_hsync      <= r_hsPipe[FETCH_LAT-1] ? HS_ON : ~HS_ON;
         r_vsync      <= r_vsPipe[FETCH_LAT-1] ? VS_ON : ~VS_ON;
         r_lineStart  <= r_firstPipe[FETCH_LAT-1];
         r_frameStart <= r_framePipe[FETCH_LAT-1];
      end else begin
         r_lineStart  <= 1'b0;
         r_frameStart <= 1'b0;
      end
   end

   assign bus.fetch_x     = r_hc;
   assign bus.fetch_y     = r_vc;
   assign bus.fetch_valid = w_deRaw;
   assign bus.pixel_out   = r_pixelOut;
   assign bus.de          = r_de;
   assign bus.hsync       = r_hsync;
   assign bus.vsync       = r_vsync;
   assign bus.line_start  = r_lineStart;
   assign bus.frame_start = r_frameStart;
   assign bus.frame_cnt   = r_frameCnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced 24x10 raster with FETCH_LAT=3, hsync active high.
// Expected outputs come from the enabled-edge count since reset release.
module tb_vga_timing_gen;

   localparam int H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
   localparam int V_ACTIVE = 6,  V_FP = 1, V_SYNC = 2, V_BP = 1;
   localparam int H_TOTAL  = 24;
   localparam int V_TOTAL  = 10;
   localparam int FRAME    = H_TOTAL * V_TOTAL;
   localparam int LAT      = 3;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   kEn;
   bit   lastEn;
   logic [7:0] mem0, mem1, mem2;

   vga_timing_gen_if #(.X_W(5), .Y_W(4), .PIXEL_W(8)) vif ();

   vga_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .PIXEL_W(8), .HSYNC_POL(1), .VSYNC_POL(0), .FETCH_LAT(LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(vif.master)
   );

   always #5 clk = ~clk;

   // Framebuffer model: returns {line[2:0], column} LAT enabled cycles after the fetch.
   always @(posedge clk) begin
      if (vif.pix_en) begin
         mem0 <= {vif.fetch_y[2:0], vif.fetch_x};
         mem1 <= mem0;
         mem2 <= mem1;
      end
   end
   assign vif.pixel_in = mem2;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s at k=%0d: got %0h, expected %0h", tag, kEn, got, exp);
      end
   endtask

   task automatic checkAll();
      int pos, fx, fy, o, c, l;
      logic eDe, eHs, eVs, eLs, eFs;
      logic [7:0] ePix;
      pos = kEn % FRAME;
      fx  = pos % H_TOTAL;
      fy  = pos / H_TOTAL;
      eDe = 1'b0; eHs = 1'b0; eVs = 1'b1; eLs = 1'b0; eFs = 1'b0; ePix = 8'd0;
      if (kEn >= LAT + 1) begin
         o   = (kEn - LAT - 1) % FRAME;
         c   = o % H_TOTAL;
         l   = o / H_TOTAL;
         eDe = (c < 16) && (l < 6);
         eHs = (c >= 18) && (c < 21);
         eVs = !((l >= 7) && (l < 9));
         eLs = lastEn && (c == 0);
         eFs = lastEn && (c == 0) && (l == 0);
`ifdef VGA_TEST_PATTERN_EN
         if (eDe) ePix = 8'((c ^ l) & 255);
`else
         if (eDe) ePix = 8'(((l & 7) << 5) | c);
`endif
      end
      checkOutput("fetch_x",     32'(vif.fetch_x),     32'(fx));
      checkOutput("fetch_y",     32'(vif.fetch_y),     32'(fy));
      checkOutput("fetch_valid", 32'(vif.fetch_valid), 32'((fx < 16) && (fy < 6)));
      checkOutput("pixel_out",   32'(vif.pixel_out),   32'(ePix));
      checkOutput("de",          32'(vif.de),          32'(eDe));
      checkOutput("hsync",       32'(vif.hsync),       32'(eHs));
      checkOutput("vsync",       32'(vif.vsync),       32'(eVs));
      checkOutput("line_start",  32'(vif.line_start),  32'(eLs));
      checkOutput("frame_start", 32'(vif.frame_start), 32'(eFs));
      checkOutput("frame_cnt",   32'(vif.frame_cnt),   32'((kEn / FRAME) % 256));
   endtask

   task automatic applyStimulus(input bit en);
      vif.pix_en = en;
      @(posedge clk);
      @(negedge clk);
      lastEn = en;
      if (en) kEn++;
      checkAll();
   endtask

   initial begin
      rst        = 1'b1;
      vif.pix_en = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
      vif.pattern_sel = 1'b1;
`endif
      kEn    = 0;
      lastEn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkAll();
      rst = 1'b0;

      // Two full frames plus a partial one, ending mid-active at column 4 line 4.
      for (int i = 0; i < 2 * FRAME + 100; i++) applyStimulus(1'b1);

      rst        = 1'b1;
      vif.pix_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      kEn    = 0;
      lastEn = 1'b0;
      checkAll();
      rst = 1'b0;

      // Enable on every 4th clk; held outputs and single-clk pulses are checked each clk.
      for (int i = 0; i < 4 * (FRAME + 10); i++) applyStimulus(i % 4 == 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; successor to the fixed 640x480 driver.
- Programmable porch/sync/active sizes, sync polarity and pixel width.
- Pixel-clock enable lets it run from the system clock.
- Issues framebuffer fetch coordinates ahead of display, compensating a configurable read latency so pixel data, sync and data-enable leave aligned.
- Sits between the camera framebuffer read port and the VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- PIXEL_W, 8, pixel data width
- HSYNC_POL, 0, hsync active level (0 = active low)
- VSYNC_POL, 0, vsync active level
- FETCH_LAT, 1, enabled cycles from fetch address to pixel_in valid; range 1..4
- Derived localparams: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; X_W = clog2(H_TOTAL); Y_W = clog2(V_TOTAL)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pix_en  in  1  pixel-clock enable; state advances only when 1
- fetch_x  out  X_W  column being fetched
- fetch_y  out  Y_W  line being fetched
- fetch_valid  out  1  fetch_x/fetch_y lie inside the active area
- pixel_in  in  PIXEL_W  framebuffer data, valid FETCH_LAT enabled cycles after its fetch
- pixel_out  out  PIXEL_W  pixel to DAC
- hsync  out  1  horizontal sync, polarity per HSYNC_POL
- vsync  out  1  vertical sync, polarity per VSYNC_POL
- de  out  1  display enable, aligned with pixel_out
- line_start  out  1  one-clk pulse with first output pixel of each line
- frame_start  out  1  one-clk pulse with pixel (0,0) at output
- frame_cnt  out  8  frames completed, wraps 255->0

Behaviour:
- Reset is synchronous, active-high, on clk. It takes priority over pix_en.
- Reset values:
  - Counters hc = 0, vc = 0.
  - Sideband pipeline cleared to de = 0 and syncs inactive.
  - Outputs: pixel_out = 0, de = 0, hsync = ~HSYNC_POL, vsync = ~VSYNC_POL, line_start = 0, frame_start = 0, frame_cnt = 0.
- Counters, on a clk with pix_en = 1:
  - hc increments.
  - When hc = H_TOTAL-1, hc wraps to 0 and vc increments.
  - When vc = V_TOTAL-1 and hc = H_TOTAL-1, vc wraps to 0 and frame_cnt increments, modulo 256.
- pix_en = 0: counters, pipeline and all outputs hold. line_start and frame_start are forced to 0.
- Fetch side:
  - fetch_x = hc and fetch_y = vc, driven straight from the counter registers.
  - fetch_valid = (hc < H_ACTIVE) && (vc < V_ACTIVE).
- Sideband pipeline:
  - Per counter position, compute: de_raw = fetch_valid; hs_raw active when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC; vs_raw active when V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC; first flag = (hc == 0); frame flag = (hc == 0 && vc == 0).
  - These pass through a FETCH_LAT-deep shift register that advances only on pix_en.
- Output register, updated on enabled cycles:
  - pixel_out = de_d ? pixel_in : 0.
  - hsync, vsync, de take the delayed values, with polarity applied.
- Latency: FETCH_LAT+1 enabled cycles from counter position to pins, identical for data and sync.
- line_start and frame_start are high for exactly one clk: the clk on which the output register loads the delayed position flag.
- Sync and de boundaries follow strict less-than compares. At defaults, hsync is active for output columns 656..751 and vsync for lines 490..491.
- Mid-frame reset restarts at (0,0). The first frame_start appears FETCH_LAT+1 enabled cycles after reset release.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined:
  - Adds input pattern_sel (1 bit).
  - x and y are carried through the sideband pipeline.
  - With pattern_sel = 1 and de_d = 1: pixel_out = low PIXEL_W bits of (x XOR y).
  - pixel_in is ignored; fetch ports behave unchanged.
- Undefined: the port, the x/y pipeline and the pattern logic are absent. pixel_out always comes from pixel_in.

Test Plan:
- Reset, pix_en = 1 held, defaults: frame_start period is 420000 clk; line_start period 800 clk; hsync low for 96 clk per line; vsync low for exactly 2 lines (1600 clk).
- FETCH_LAT = 3, pixel_in = low 8 bits of fetch_x delayed 3 enabled cycles: pixel_out equals column index on every de cycle; pixel_out = 0 whenever de = 0; de is high 640 clk per line and 480 lines per frame.
- pix_en asserted every 4th clk: all periods scale by 4; line_start and frame_start are single-clk pulses; outputs hold steady across disabled clks.
- HSYNC_POL = 1, VSYNC_POL = 1: hsync is high during columns 656..751 and low otherwise; after reset both syncs are 0.
- Reset asserted at (hc 300, vc 200): next enabled cycle shows fetch_x = 0 and fetch_y = 0; frame_cnt = 0; the in-flight pipeline is flushed, so de stays 0 until the first valid output.
- VGA_TEST_PATTERN_EN with pattern_sel = 1: the pixel at (5,3) outputs 8'h06; frame_cnt reaches 2 after two full frames.
